// File: rtl/seq_sub32.sv
// Byte-serial 32-bit subtractor: D = A1 - A2 - bin, one 8-bit slice per clock.
// Results and flags are registered and only change on the done cycle.
module seq_sub32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A1,
    input  logic [31:0] A2,
    input  logic        bin,
    output logic [31:0] D,
    output logic        B,
    output logic        V,
    output logic        Z,
    output logic        busy,
    output logic        done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [1:0]  k_r;
    logic        borrow_r;
    logic [31:0] a1_r;
    logic [31:0] a2_r;
    logic [23:0] shadow_r;

    logic [7:0]  a_byte_s;
    logic [7:0]  b_byte_s;
    logic [8:0]  diff_s;
    logic        accept_s;
    logic        last_s;
    logic [31:0] result_s;

    // Slice select and 9-bit subtract; bit 8 is the borrow out of the slice
    always_comb begin
        a_byte_s = 8'h00;
        b_byte_s = 8'h00;
        case (k_r)
            2'd0: begin a_byte_s = a1_r[7:0];   b_byte_s = a2_r[7:0];   end
            2'd1: begin a_byte_s = a1_r[15:8];  b_byte_s = a2_r[15:8];  end
            2'd2: begin a_byte_s = a1_r[23:16]; b_byte_s = a2_r[23:16]; end
            2'd3: begin a_byte_s = a1_r[31:24]; b_byte_s = a2_r[31:24]; end
            default: begin a_byte_s = 8'h00; b_byte_s = 8'h00; end
        endcase
        diff_s   = {1'b0, a_byte_s} - {1'b0, b_byte_s} - {8'h00, borrow_r};
        result_s = {diff_s[7:0], shadow_r};
    end

    // Next-state logic and handshake decode
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (k_r == 2'd3) begin
                    last_s     = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture, slice iteration, and result/flag update at completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_r      <= 2'd0;
            borrow_r <= 1'b0;
            a1_r     <= 32'h0000_0000;
            a2_r     <= 32'h0000_0000;
            shadow_r <= 24'h00_0000;
            D        <= 32'h0000_0000;
            B        <= 1'b0;
            V        <= 1'b0;
            Z        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state_nx_s == RUN);
            done <= last_s;
            if (accept_s) begin
                a1_r     <= A1;
                a2_r     <= A2;
                borrow_r <= bin;
                k_r      <= 2'd0;
            end else if (state_r == RUN) begin
                borrow_r <= diff_s[8];
                k_r      <= k_r + 2'd1;
                case (k_r)
                    2'd0: shadow_r[7:0]   <= diff_s[7:0];
                    2'd1: shadow_r[15:8]  <= diff_s[7:0];
                    2'd2: shadow_r[23:16] <= diff_s[7:0];
                    default: shadow_r     <= shadow_r;
                endcase
                // The top byte goes straight to D; it is never needed again
                if (last_s) begin
                    D <= result_s;
                    B <= diff_s[8];
                    V <= (a1_r[31] ^ a2_r[31]) & (diff_s[7] ^ a1_r[31]);
                    Z <= (result_s == 32'h0000_0000);
                end else begin
                    D <= D;
                end
            end else begin
                k_r <= k_r;
            end
        end
    end

endmodule

// File: tb/tb_seq_sub32.sv
// Self-checking bench for seq_sub32: directed cases plus random operands
// against a plain-arithmetic reference model.
module tb_seq_sub32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] A1;
    logic [31:0] A2;
    logic        bin;
    logic [31:0] D;
    logic        B;
    logic        V;
    logic        Z;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] last_d;
    logic        last_b;
    logic        last_v;
    logic        last_z;

    seq_sub32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A1    (A1),
        .A2    (A2),
        .bin   (bin),
        .D     (D),
        .B     (B),
        .V     (V),
        .Z     (Z),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word 33-bit subtract; V by the sign rule on operands and result
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                         output logic [31:0] d, output logic bo, output logic vo, output logic zo);
        logic [32:0] wide;
        wide = {1'b0, a} - {1'b0, b} - {32'd0, bi};
        d    = wide[31:0];
        bo   = wide[32];
        vo   = (a[31] != b[31]) && (d[31] != a[31]);
        zo   = (d == 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; start is presented for exactly one rising edge
    task automatic do_accept(input logic [31:0] a, input logic [31:0] b, input logic bi);
        start = 1'b1;
        A1    = a;
        A2    = b;
        bin   = bi;
        step();
        start = 1'b0;
        A1    = $urandom;
        A2    = $urandom;
        bin   = 1'($urandom_range(1, 0));
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("done_after_accept", {31'd0, done}, 32'd0);
    endtask

    // Continues from the negedge after accept: three busy cycles, then the done cycle
    task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bi);
        logic [31:0] ed;
        logic        eb;
        logic        ev;
        logic        ez;
        model(a, b, bi, ed, eb, ev, ez);
        for (int i = 1; i < 4; i++) begin
            step();
            check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
            check({tag, "_done_mid"}, {31'd0, done}, 32'd0);
            check({tag, "_D_hold"}, D, last_d);
            check({tag, "_BVZ_hold"}, {29'd0, B, V, Z}, {29'd0, last_b, last_v, last_z});
        end
        step();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_D"}, D, ed);
        check({tag, "_B"}, {31'd0, B}, {31'd0, eb});
        check({tag, "_V"}, {31'd0, V}, {31'd0, ev});
        check({tag, "_Z"}, {31'd0, Z}, {31'd0, ez});
        last_d = ed;
        last_b = eb;
        last_v = ev;
        last_z = ez;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bi);
        do_accept(a, b, bi);
        finish_op(tag, a, b, bi);
        step();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rbi;

        rst_n  = 1'b0;
        start  = 1'b1;
        A1     = 32'hDEAD_BEEF;
        A2     = 32'h0000_0001;
        bin    = 1'b0;
        last_d = 32'd0;
        last_b = 1'b0;
        last_v = 1'b0;
        last_z = 1'b0;
        step();
        step();
        check("reset_D", D, 32'd0);
        check("reset_flags", {28'd0, B, V, Z, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        step();

        run_op("basic", 32'd5, 32'd3, 1'b0);
        run_op("underflow", 32'd0, 32'd1, 1'b0);
        run_op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b0);
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("bin_zero", 32'h1234_5678, 32'h1234_5677, 1'b1);

        // Handshake: mid-run start ignored, back-to-back start on the done cycle
        do_accept(32'd10, 32'd4, 1'b0);
        step();
        start = 1'b1;
        A1    = 32'd99;
        A2    = 32'd1;
        step();
        start = 1'b0;
        check("hs_busy_e2", {31'd0, busy}, 32'd1);
        step();
        step();
        check("hs_done1", {31'd0, done}, 32'd1);
        check("hs_D1", D, 32'd6);
        last_d = 32'd6;
        last_b = 1'b0;
        last_v = 1'b0;
        last_z = 1'b0;
        do_accept(32'd7, 32'd7, 1'b0);
        finish_op("hs2", 32'd7, 32'd7, 1'b0);
        step();
        check("hs2_done_pulse", {31'd0, done}, 32'd0);

        // Reset during RUN: abandons the operation and clears the outputs
        do_accept(32'hFFFF_0000, 32'd1, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_D", D, 32'd0);
        check("rst_mid_BVZ", {29'd0, B, V, Z}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        last_d = 32'd0;
        last_b = 1'b0;
        last_v = 1'b0;
        last_z = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_no_done", {31'd0, done}, 32'd0);
            check("rst_idle", {31'd0, busy}, 32'd0);
        end
        run_op("after_rst", 32'd3, 32'd1, 1'b0);

        // Random operands, alternating idle gaps and back-to-back issue
        for (int n = 0; n < 24; n++) begin
            ra  = $urandom;
            rb  = (n % 5 == 0) ? ra : $urandom;
            rbi = 1'($urandom_range(1, 0));
            do_accept(ra, rb, rbi);
            finish_op("rand", ra, rb, rbi);
            if (n % 2 == 0) begin
                step();
                check("rand_done_pulse", {31'd0, done}, 32'd0);
            end
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
